arinc429_tx_encoder: RTL
========================

// Module: arinc429_tx_encoder
// PURPOSE
//   ARINC 429 transmit encoder; the Tx counterpart of the receive Decoder.
//   - Accepts a 32-bit word and serialises it LSB first as bipolar RZ on the High/Low line pair.
//   - Inserts the mandatory inter-word null gap after each word.
//   - Sits between the host/register interface and the line-driver pins.
// PARAMETERS
//   HALF_HS   100  Clk cycles per half-bit at 100 kbit/s (20 MHz Clk)
//   HALF_LS   800  Clk cycles per half-bit at 12.5 kbit/s (20 MHz Clk)
//   GAP_BITS  4    null bit-times inserted after every word (min 4)
// PORTS
//   Clk    in   1   system clock, all logic rising-edge
//   Rst    in   1   asynchronous, active-high reset
//   Data   in   32  word to send; Data[0] is transmitted first
//   Load   in   1   request; accepted on a Clk edge where Load && Ready
//   speed  in   1   1 = 100 kbit/s, 0 = 12.5 kbit/s; sampled at accept
//   Ready  out  1   encoder idle, can accept a word
//   High   out  1   line A drive; 1 during first half of a '1' bit
//   Low    out  1   line B drive; 1 during first half of a '0' bit
//   Done   out  1   one-cycle pulse when the gap after a word completes
// BEHAVIOUR
//   - Reset: all outputs 0 except Ready=1; state IDLE; counters 0. Async assert,
//     so High/Low go null immediately even mid-word. After release, the first
//     accept is possible on the next edge.
//   - FSM: IDLE -> HALF_ON -> HALF_NULL -> (HALF_ON | GAP) -> IDLE.
//     - IDLE: Ready=1. On Load, capture Data into shift reg, latch speed,
//       bit_cnt=0, go HALF_ON. Ready falls on the same edge.
//     - HALF_ON: High=sh[0], Low=~sh[0] for HALF cycles.
//     - HALF_NULL: High=Low=0 for HALF cycles. Then shift right and bit_cnt+1.
//       If bit_cnt was 31, go GAP; else go HALF_ON.
//     - GAP: lines null for GAP_BITS*2*HALF cycles. On the last cycle Done=1,
//       and on the next edge the FSM is in IDLE with Ready=1.
//   - Latency: accept on edge N; High/Low valid from edge N+1.
//   - Word time: (32+GAP_BITS)*2*HALF cycles from accept to Ready. This is
//     7200 cycles at 100k and 57600 at 12.5k.
//   - Load while Ready=0 is ignored (no queue). Data and speed changes mid-word
//     have no effect.
//   - High and Low are never both 1 in any cycle (assertion).
//   - Half-bit counter is 10 bits, counts 0..HALF-1 and wraps to 0 at each
//     phase change. HALF is selected by the latched speed.
//   - Outputs are registered; no combinational path from inputs to High/Low.
// CONFIGURATION
//   ARINC_TX_PARITY_EN defined:
//   - Transmitted bit 31 is replaced by odd parity over Data[30:0].
//   - Data[31] is ignored.
//   Not defined:
//   - Data[31] is sent verbatim.
// STRUCTURE
//   - Shared header arinc429_defs.vh: FSM state encodings, HALF_HS/HALF_LS
//     defaults, SPEED_HS=1/SPEED_LS=0, word width 32. The Decoder uses the
//     same header.
//   - One sub-module, arinc_tx_timer:
//     - Inputs: half-period select, start, gap mode.
//     - Outputs: half_tick and gap_done.
//     - The encoder FSM instantiates it.
// TESTING
//   1. Data=32'h0000_0001, speed=1, Load 1 cycle -> High=1 for 100 cycles,
//      null 100, then 31 Low pulses of 100. Done at +7200, Ready=1 next cycle.
//   2. Data=32'hFFFF_FFFF, speed=0 -> 32 High pulses of 800 cycles, no Low
//      activity, Ready after 57600 cycles.
//   3. Loopback to the Decoder with Data=32'hA5C3_0F17 at each speed ->
//      Decoder Out equals the word (with parity variant: bit31 = odd parity).
//   4. Load held high with new Data during a word -> second word starts only
//      after Done. The first word is sent unchanged.
//   5. Rst pulsed at bit 10 -> High=Low=0 within the reset cycle, Ready=1,
//      Done never pulses. A subsequent word is sent cleanly.
//   6. Toggle speed mid-word -> bit timing unchanged until the next accept.

Source files
------------

// File: rtl/arinc429_tx_encoder_pkg.sv
// Shared ARINC 429 Tx definitions: word width, default half-bit periods, speed codes, FSM states.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package arinc429_tx_encoder_pkg;

   localparam int WORD_W       = 32;
   localparam int HALF_HS_DEF  = 100;   // 100 kbit/s at 20 MHz
   localparam int HALF_LS_DEF  = 800;   // 12.5 kbit/s at 20 MHz
   localparam int GAP_BITS_DEF = 4;

   localparam logic SPEED_HS = 1'b1;
   localparam logic SPEED_LS = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HALF_ON   = 2'd1,
      ST_HALF_NULL = 2'd2,
      ST_GAP       = 2'd3
   } tx_state_t;

   // Bit that makes the total count of ones across the 32-bit word odd.
   function automatic logic odd_parity(input logic [WORD_W-2:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/arinc429_tx_encoder_if.sv
// Host/line-side bundle of the ARINC 429 transmit encoder.
// Latency: n/a (wiring only).
// Backpressure: Load is honoured only while Ready is high; there is no queue.
interface arinc429_tx_encoder_if;

   logic [arinc429_tx_encoder_pkg::WORD_W-1:0] Data;
   logic                                       Load;
   logic                                       speed;
   logic                                       Ready;
   logic                                       High;
   logic                                       Low;
   logic                                       Done;

   modport master (output Data, Load, speed, input Ready, High, Low, Done);
   modport slave  (input Data, Load, speed, output Ready, High, Low, Done);

endinterface

// File: rtl/arinc429_tx_encoder_timer.sv
// Half-bit and inter-word gap timer for the ARINC 429 encoder.
// Latency: half_tick on the last cycle of each half-bit; gap_done on the last cycle of the gap.
// Backpressure: none; held cleared while start is high.
module arinc429_tx_encoder_timer
   import arinc429_tx_encoder_pkg::*;
#(
   parameter int HALF_HS  = HALF_HS_DEF,
   parameter int HALF_LS  = HALF_LS_DEF,
   parameter int GAP_BITS = GAP_BITS_DEF
) (
   input  logic Clk,
   input  logic Rst,
   input  logic half_sel,
   input  logic start,
   input  logic gap_mode,
   output logic half_tick,
   output logic gap_done
);

   localparam int GAP_HALVES = 2 * GAP_BITS;
   localparam int GW         = $clog2(GAP_HALVES);

   logic [9:0]    half_cnt;
   logic [9:0]    half_max;
   logic [GW-1:0] gap_cnt;

   assign half_max  = (half_sel == SPEED_HS) ? 10'(HALF_HS - 1) : 10'(HALF_LS - 1);
   assign half_tick = (half_cnt == half_max);
   assign gap_done  = gap_mode && half_tick && (gap_cnt == GW'(GAP_HALVES - 1));

   // Half-bit counter: 0..HALF-1, wrapping at every phase change.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         half_cnt <= '0;
      end else if (start || half_tick) begin
         half_cnt <= '0;
      end else begin
         half_cnt <= half_cnt + 10'd1;
      end
   end

   // Gap counter: number of completed null half-bits since the gap began.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         gap_cnt <= '0;
      end else if (start || !gap_mode) begin
         gap_cnt <= '0;
      end else if (half_tick) begin
         gap_cnt <= gap_cnt + GW'(1);
      end
   end

endmodule

// File: rtl/arinc429_tx_encoder.sv
// ARINC 429 transmitter: 32-bit word out LSB first as bipolar RZ on High/Low, then a null gap; ARINC_TX_PARITY_EN puts odd parity in bit 31.
// Latency: accept on edge N, line drive from edge N+1; Ready returns (32+GAP_BITS)*2*HALF cycles after accept.
// Backpressure: Ready low for the whole word and gap; Load while busy is dropped, no queue.
module arinc429_tx_encoder
   import arinc429_tx_encoder_pkg::*;
#(
   parameter int HALF_HS  = HALF_HS_DEF,
   parameter int HALF_LS  = HALF_LS_DEF,
   parameter int GAP_BITS = GAP_BITS_DEF
) (
   input  logic                  Clk,
   input  logic                  Rst,
   arinc429_tx_encoder_if.slave  bus
);

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic              accept;
   logic              done;
   logic [WORD_W-1:0] word_in;
   logic [WORD_W-1:0] sh;
   logic [4:0]        bit_cnt;
   logic              spd;
   logic              high_q;
   logic              low_q;
   logic              half_tick;
   logic              gap_done;

`ifdef ARINC_TX_PARITY_EN
   assign word_in = {odd_parity(bus.Data[WORD_W-2:0]), bus.Data[WORD_W-2:0]};
`else
   assign word_in = bus.Data;
`endif

   arinc429_tx_encoder_timer #(
      .HALF_HS  (HALF_HS),
      .HALF_LS  (HALF_LS),
      .GAP_BITS (GAP_BITS)
   ) u_timer (
      .Clk       (Clk),
      .Rst       (Rst),
      .half_sel  (spd),
      .start     (state == ST_IDLE),
      .gap_mode  (state == ST_GAP),
      .half_tick (half_tick),
      .gap_done  (gap_done)
   );

   // State register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, accept strobe and end-of-gap pulse.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.Load) begin
               accept    = 1'b1;
               state_nxt = ST_HALF_ON;
            end
         end
         ST_HALF_ON: begin
            if (half_tick) state_nxt = ST_HALF_NULL;
         end
         ST_HALF_NULL: begin
            if (half_tick) state_nxt = (bit_cnt == 5'(WORD_W - 1)) ? ST_GAP : ST_HALF_ON;
         end
         ST_GAP: begin
            if (gap_done) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Word capture, shifting after each null half, and registered line drive.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sh      <= '0;
         bit_cnt <= '0;
         spd     <= 1'b0;
         high_q  <= 1'b0;
         low_q   <= 1'b0;
      end else begin
         if (accept) begin
            sh      <= word_in;
            spd     <= bus.speed;
            bit_cnt <= '0;
         end else if (state == ST_HALF_NULL && half_tick) begin
            sh      <= {1'b0, sh[WORD_W-1:1]};
            bit_cnt <= bit_cnt + 5'd1;
         end
         high_q <= (state == ST_HALF_ON) &&  sh[0];
         low_q  <= (state == ST_HALF_ON) && !sh[0];
      end
   end

   assign bus.Ready = (state == ST_IDLE);
   assign bus.Done  = done;
   assign bus.High  = high_q;
   assign bus.Low   = low_q;

   // Both line drivers active at once would short the bipolar pair.
   a_no_both_lines: assert property (@(posedge Clk) disable iff (Rst) !(high_q && low_q));

endmodule
